// File: rtl/argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module      : argmax_pkg
// Description : Shared types and helpers for the argmax output stage.
//               State encoding and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package argmax_pkg;

    // Frame controller states: gathering neuron values, or presenting a result
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Index width for M neurons; never narrower than one bit
    function automatic int idx_width(input int m);
        int w;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/argmax_cmp.sv
`default_nettype none
// ============================================================================
// Module      : argmax_cmp
// Description : Combinational signed compare/select of the running best
//               (value, index) against the incoming candidate.
//               Tie rule: define ARGMAX_TIE_LAST_EN to make the latest index
//               win on equal values; otherwise the first occurrence wins.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_cmp #(
    parameter int T     = 16,
    parameter int IDX_W = 4
) (
    input  logic                    first,
    input  logic signed [T-1:0]     best_val,
    input  logic        [IDX_W-1:0] best_idx,
    input  logic signed [T-1:0]     cand_val,
    input  logic        [IDX_W-1:0] cand_idx,
    output logic signed [T-1:0]     sel_val,
    output logic        [IDX_W-1:0] sel_idx
);

    logic w_take;

    // The first beat of a frame always seeds the running best, so stale
    // contents from a previous frame never take part in the compare.
`ifdef ARGMAX_TIE_LAST_EN
    assign w_take = first || (cand_val >= best_val);
`else
    assign w_take = first || (cand_val > best_val);
`endif

    assign sel_val = w_take ? cand_val : best_val;
    assign sel_idx = w_take ? cand_idx : best_idx;

endmodule
`default_nettype wire

// File: rtl/argmax_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : argmax_out_stage
// Description : Consumes M signed neuron values per frame over valid/ready,
//               tracks the running maximum and emits one (index, max) result
//               beat per frame. Upstream is stalled while a result is held.
//               Optional macro ARGMAX_TIE_LAST_EN (in argmax_cmp) selects
//               last-occurrence tie-breaking.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_out_stage
    import argmax_pkg::*;
#(
    parameter  int M     = 16,
    parameter  int T     = 16,
    localparam int IDX_W = idx_width(M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [T-1:0]     input_data,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [IDX_W-1:0] output_index,
    output logic [T-1:0]     output_max
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(M - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_count;
    logic signed [T-1:0] r_best_val;
    logic [IDX_W-1:0]   r_best_idx;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_out_idx;
    logic [T-1:0]       r_out_max;

    logic signed [T-1:0] w_sel_val;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_accept;

    assign w_accept = input_valid && r_in_ready;

    argmax_cmp #(
        .T     (T),
        .IDX_W (IDX_W)
    ) u_cmp (
        .first    (r_count == '0),
        .best_val (r_best_val),
        .best_idx (r_best_idx),
        .cand_val (input_data),
        .cand_idx (r_count),
        .sel_val  (w_sel_val),
        .sel_idx  (w_sel_idx)
    );

    // Frame controller: accumulate the running best in COLLECT, present the
    // result in HOLD with upstream stalled until downstream takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_count     <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_max   <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_best_val <= w_sel_val;
                        r_best_idx <= w_sel_idx;
                        if (r_count == c_LAST) begin
                            // Final beat is folded into the result directly
                            r_out_idx   <= w_sel_idx;
                            r_out_max   <= w_sel_val;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_count     <= '0;
                            r_state     <= HOLD;
                        end else begin
                            r_count <= r_count + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (output_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= COLLECT;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign input_ready  = r_in_ready;
    assign output_valid = r_out_valid;
    assign output_index = r_out_idx;
    assign output_max   = r_out_max;

endmodule
`default_nettype wire

// File: doc/argmax_out_stage.md
Name: argmax_out_stage

Overview:
- Downstream consumer of a fully-connected layer's serial output stream (T-bit signed, one neuron value per beat, M beats per frame).
- Each frame is M values; the block tracks the running maximum, then presents the winning neuron index and its value as one result beat.
- Sits after the final fc layer to turn raw scores into a classification.
- Uses valid/ready handshakes on both sides.

Parameters:
- M, 16, neurons per frame (values consumed per result); M >= 2.
- T, 16, signed data width of each input value.
- IDX_W, $clog2(M), width of the index output; derived localparam, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- input_valid  input  1  upstream has a value on input_data.
- input_ready  output  1  block accepts a value this cycle.
- input_data  input  T  signed neuron value.
- output_valid  output  1  result beat is valid.
- output_ready  input  1  downstream accepts the result.
- output_index  output  IDX_W  index (0..M-1, arrival order) of the maximum.
- output_max  output  T  signed maximum value.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=COLLECT, count=0, input_ready=1, output_valid=0, output_index=0, output_max=0, best registers cleared.
- Accept rule: a beat is accepted when input_valid && input_ready. Output transfer occurs when output_valid && output_ready.
- COLLECT state:
  - input_ready=1 and output_valid=0.
  - On accept with count==0: best_val<=input_data, best_idx<=0.
  - On accept with count>0: if input_data > best_val (signed compare), best_val<=input_data and best_idx<=count.
  - Default tie-break: the first occurrence wins.
  - count increments on every accept.
  - On the accept where count==M-1:
    - The last value is included in the compare.
    - output_index/output_max are loaded from the final result.
    - count<=0 and state<=HOLD.
  - input_valid=0 cycles change nothing.
- HOLD state:
  - input_ready=0, output_valid=1.
  - output_index/output_max are stable until the transfer.
  - On output_ready: state<=COLLECT and output_valid<=0. input_ready returns to 1 on the next cycle, with no overlap between frames.
- Latency: output_valid rises on the cycle after the final (M-th) accept. Minimum frame period is M+1 cycles when output_ready is held high.
- Backpressure: upstream is stalled in HOLD, so no beat is lost or reordered.
- Boundaries:
  - All-equal values: index 0.
  - All-negative values: the true signed maximum is reported (the reset value 0 must not leak in).
  - Most-negative value (-2^(T-1)): handled correctly.
  - count wraps at M exactly, also for M not a power of two.
- Reset mid-frame or in HOLD: partial frame discarded, registers return to reset values, and the next accept is treated as beat 0.

Optional Feature:
- Macro ARGMAX_TIE_LAST_EN.
- Defined: the compare is >=, so on ties the latest index wins.
- Undefined: the compare is strict >, so the first occurrence wins.
- Ports and timing are identical in both cases.

Decomposition:
- Package argmax_pkg:
  - idx_width(M) function returning max(1,$clog2(M)).
  - State enum typedef {COLLECT, HOLD}.
- One sub-module, argmax_cmp: combinational signed compare/select of (best_val, best_idx) vs (input_data, count).
  - The tie rule lives only here, under ARGMAX_TIE_LAST_EN.

Test Plan:
- Sequence 5,-3,9,2,0,...,0 (16 beats), output_ready=1 -> output_valid 1 cycle after beat 16; index=2, max=9; input_ready back the next cycle.
- All 16 beats = -100 -> index=0, max=-100. All beats negative with -1 at index 15 -> index=15, max=-1.
- Value 7 at indices 3 and 11, others smaller -> index=3 without the macro, index=11 with ARGMAX_TIE_LAST_EN.
- output_ready low 10 cycles after the result -> output_valid, index and max held stable; input_ready=0 and no beats accepted; transfer on ready, then the second frame's result is correct.
- Random input_valid gaps (50% duty) over 100 frames -> matches the reference model argmax; exactly one result per 16 accepts.
- Reset asserted after 7 beats, then a full new frame -> result reflects only the new frame; all outputs at reset values during reset.
